nmea_frame_check: RTL and testbench

NMEA_FRAME_CHECK -- requirements
Module: nmea_frame_check

---
 rtl/nmea_pkg.sv | 33 +++
 rtl/nmea_hexnib.sv | 23 ++
 rtl/nmea_frame_check.sv | 196 +++++++++++++++++++
 tb/tb_nmea_frame_check.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmea_pkg.sv
// Shared types and constants for the NMEA sentence framing checker.
package nmea_pkg;

    localparam int unsigned MAX_LEN_DEFAULT = 82;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_BODY  = 3'd1,
        ST_CK_HI = 3'd2,
        ST_CK_LO = 3'd3,
        ST_CR    = 3'd4,
        ST_LF    = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_CKSUM   = 2'b01,
        ERR_FORMAT  = 2'b10,
        ERR_OVERLEN = 2'b11
    } err_e;

    // Frame termination report carried alongside frame_done.
    typedef struct packed {
        logic ok;
        err_e err;
    } frame_status_t;

endpackage

// File: rtl/nmea_hexnib.sv
// ASCII uppercase hex digit to nibble decoder.
module nmea_hexnib
    import nmea_pkg::*;
(
    input  logic [7:0] char_i,
    output logic [3:0] nib_o,
    output logic       is_hex_o
);

    // '0'-'9' map to their low nibble; 'A'-'F' sit at 0x41..0x46, so add 9.
    always_comb begin
        nib_o    = 4'h0;
        is_hex_o = 1'b0;
        if (char_i >= 8'h30 && char_i <= 8'h39) begin
            nib_o    = char_i[3:0];
            is_hex_o = 1'b1;
        end else if (char_i >= 8'h41 && char_i <= 8'h46) begin
            nib_o    = 4'(char_i[3:0] + 4'd9);
            is_hex_o = 1'b1;
        end
    end

endmodule

// File: rtl/nmea_frame_check.sv
// Inline NMEA sentence checker: forwards frame bytes through a one-entry
// output register and reports checksum/format/length status per frame.
module nmea_frame_check
    import nmea_pkg::*;
#(
    parameter int unsigned MAX_LEN_P = MAX_LEN_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic [7:0]  data_i,
    output logic        ready_o,
    output logic        valid_o,
    output logic [7:0]  data_o,
    input  logic        ready_i,
    output logic        frame_done_o,
    output logic        frame_ok_o,
    output logic [1:0]  err_code_o,
    output logic [15:0] good_count_o,
    output logic [15:0] bad_count_o
);

    localparam int unsigned LEN_W = $clog2(MAX_LEN_P + 1);
    localparam int unsigned CNT_W = 16;

    state_e             state_q, state_d;
    logic [7:0]         xor_q, xor_d;
    logic [7:0]         ck_q, ck_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               valid_q, valid_d;
    logic [7:0]         data_q, data_d;
    logic               done_q, done_d;
    frame_status_t      status_q, status_d;
    logic [CNT_W-1:0]   good_q, good_d;
    logic [CNT_W-1:0]   bad_q, bad_d;

    logic               accept;
    logic               fwd;
    logic               term;
    frame_status_t      term_status;
    logic [3:0]         nib;
    logic               is_hex;

    nmea_hexnib u_hexnib (
        .char_i   (data_i),
        .nib_o    (nib),
        .is_hex_o (is_hex)
    );

    assign ready_o      = ~valid_q | ready_i;
    assign accept       = valid_i & ready_o;
    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign frame_done_o = done_q;
    assign frame_ok_o   = status_q.ok;
    assign err_code_o   = status_q.err;
    assign good_count_o = good_q;
    assign bad_count_o  = bad_q;

    // State register and all datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_HUNT;
            xor_q    <= 8'h00;
            ck_q     <= 8'h00;
            len_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
            done_q   <= 1'b0;
            status_q <= '{ok: 1'b0, err: ERR_NONE};
            good_q   <= '0;
            bad_q    <= '0;
        end else begin
            state_q  <= state_d;
            xor_q    <= xor_d;
            ck_q     <= ck_d;
            len_q    <= len_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            done_q   <= done_d;
            status_q <= status_d;
            good_q   <= good_d;
            bad_q    <= bad_d;
        end
    end

    // Frame parser: '$' always restarts, then length limit, then per-state rules.
    always_comb begin
        state_d     = state_q;
        xor_d       = xor_q;
        ck_d        = ck_q;
        len_d       = len_q;
        fwd         = 1'b0;
        term        = 1'b0;
        term_status = '{ok: 1'b0, err: ERR_NONE};

        if (accept) begin
            if (data_i == CH_DOLLAR) begin
                if (state_q != ST_HUNT) begin
                    term            = 1'b1;
                    term_status.err = ERR_FORMAT;
                end
                state_d = ST_BODY;
                xor_d   = 8'h00;
                len_d   = LEN_W'(1);
                fwd     = 1'b1;
            end else if (state_q == ST_HUNT) begin
                state_d = ST_HUNT;
            end else if (len_q >= LEN_W'(MAX_LEN_P)) begin
                term            = 1'b1;
                term_status.err = ERR_OVERLEN;
                state_d         = ST_HUNT;
            end else begin
                len_d = len_q + LEN_W'(1);
                fwd   = 1'b1;
                case (state_q)
                    ST_BODY: begin
                        if (data_i == CH_STAR) begin
                            state_d = ST_CK_HI;
                        end else begin
                            xor_d = xor_q ^ data_i;
                        end
                    end
                    ST_CK_HI: begin
                        if (is_hex) begin
                            ck_d    = {nib, 4'h0};
                            state_d = ST_CK_LO;
                        end else begin
                            term            = 1'b1;
                            term_status.err = ERR_FORMAT;
                            state_d         = ST_HUNT;
                        end
                    end
                    ST_CK_LO: begin
                        if (is_hex) begin
                            ck_d    = {ck_q[7:4], nib};
                            state_d = ST_CR;
                        end else begin
                            term            = 1'b1;
                            term_status.err = ERR_FORMAT;
                            state_d         = ST_HUNT;
                        end
                    end
                    ST_CR: begin
                        if (data_i == CH_CR) begin
                            state_d = ST_LF;
                        end else begin
                            term            = 1'b1;
                            term_status.err = ERR_FORMAT;
                            state_d         = ST_HUNT;
                        end
                    end
                    ST_LF: begin
                        term    = 1'b1;
                        state_d = ST_HUNT;
                        if (data_i != CH_LF) begin
                            term_status.err = ERR_FORMAT;
                        end else if (ck_q == xor_q) begin
                            term_status.ok = 1'b1;
                        end else begin
                            term_status.err = ERR_CKSUM;
                        end
                    end
                    default: begin
                        state_d = ST_HUNT;
                    end
                endcase
            end
        end
    end

    // Output register, status pulse and saturating statistics.
    always_comb begin
        valid_d  = valid_q;
        data_d   = data_q;
        done_d   = term;
        status_d = term_status;
        good_d   = good_q;
        bad_d    = bad_q;

        if (fwd) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end

        if (term && term_status.ok && (good_q != {CNT_W{1'b1}})) begin
            good_d = good_q + CNT_W'(1);
        end
        if (term && !term_status.ok && (bad_q != {CNT_W{1'b1}})) begin
            bad_d = bad_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_nmea_frame_check.sv
// Scoreboard bench for nmea_frame_check with a sentence-level reference model.
`timescale 1ns/1ps
module tb_nmea_frame_check;

    localparam int MAX_LEN = 82;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        valid_i;
    logic [7:0]  data_i;
    logic        ready_o;
    logic        valid_o;
    logic [7:0]  data_o;
    logic        ready_i;
    logic        frame_done_o;
    logic        frame_ok_o;
    logic [1:0]  err_code_o;
    logic [15:0] good_count_o;
    logic [15:0] bad_count_o;

    nmea_frame_check #(.MAX_LEN_P(MAX_LEN)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .valid_i      (valid_i),
        .data_i       (data_i),
        .ready_o      (ready_o),
        .valid_o      (valid_o),
        .data_o       (data_o),
        .ready_i      (ready_i),
        .frame_done_o (frame_done_o),
        .frame_ok_o   (frame_ok_o),
        .err_code_o   (err_code_o),
        .good_count_o (good_count_o),
        .bad_count_o  (bad_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit         ok;
        logic [1:0] err;
    } done_t;

    int         checks = 0;
    int         errors = 0;
    int         stall_pct = 0;
    bit         gaps_en = 1'b0;

    logic [7:0] exp_fwd[$];
    done_t      exp_done[$];

    // reference model state: bytes of the current frame, from '$' onward
    bit         in_frame = 1'b0;
    logic [7:0] fr[$];
    int         good_m = 0;
    int         bad_m = 0;

    function automatic void chk(input string name, input bit ok,
                                input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic bit is_hex(input logic [7:0] c);
        return (c >= "0" && c <= "9") || (c >= "A" && c <= "F");
    endfunction

    function automatic int hexval(input logic [7:0] c);
        return (c <= "9") ? int'(c) - 48 : int'(c) - 55;
    endfunction

    function automatic logic [7:0] hexchar(input logic [3:0] n);
        return (n < 4'd10) ? 8'(8'h30 + 8'(n)) : 8'(8'h37 + 8'(n));
    endfunction

    function automatic void end_frame(input bit ok, input logic [1:0] err);
        done_t d;
        d.ok  = ok;
        d.err = err;
        exp_done.push_back(d);
        if (ok) begin
            if (good_m < 65535) good_m++;
        end else begin
            if (bad_m < 65535) bad_m++;
        end
    endfunction

    // Feed one accepted byte to the model; returns 1 if it must be forwarded.
    function automatic bit model_byte(input logic [7:0] b);
        int star;
        int off;
        int x;
        int rx;
        if (b == "$") begin
            if (in_frame) end_frame(1'b0, 2'b10);
            in_frame = 1'b1;
            fr = {};
            fr.push_back(b);
            exp_fwd.push_back(b);
            return 1'b1;
        end
        if (!in_frame) return 1'b0;
        if (fr.size() == MAX_LEN) begin
            end_frame(1'b0, 2'b11);
            in_frame = 1'b0;
            return 1'b0;
        end
        fr.push_back(b);
        exp_fwd.push_back(b);
        star = -1;
        for (int i = 1; i < fr.size(); i++) begin
            if (fr[i] == "*") begin
                star = i;
                break;
            end
        end
        if (star < 0) return 1'b1;
        off = fr.size() - 1 - star;
        if (off == 0) return 1'b1;
        if (((off == 1 || off == 2) && !is_hex(b)) ||
            (off == 3 && b != 8'h0d) ||
            (off == 4 && b != 8'h0a)) begin
            end_frame(1'b0, 2'b10);
            in_frame = 1'b0;
        end else if (off == 4) begin
            x = 0;
            for (int i = 1; i < star; i++) x = x ^ int'(fr[i]);
            rx = hexval(fr[star+1]) * 16 + hexval(fr[star+2]);
            end_frame(rx == x, (rx == x) ? 2'b00 : 2'b01);
            in_frame = 1'b0;
        end
        return 1'b1;
    endfunction

    // Downstream readiness, redrawn every cycle.
    initial begin
        ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            ready_i = ($urandom_range(0, 99) >= stall_pct);
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents output.
    initial begin
        done_t e;
        logic [7:0] eb;
        forever begin
            @(negedge clk_i);
            if (rst_ni) begin
                if (valid_o && ready_i) begin
                    if (exp_fwd.size() == 0) begin
                        chk("fwd_extra", 1'b0, longint'(data_o), 0);
                    end else begin
                        eb = exp_fwd.pop_front();
                        chk("fwd_data", data_o == eb, longint'(data_o), longint'(eb));
                    end
                end
                if (frame_done_o) begin
                    if (exp_done.size() == 0) begin
                        chk("done_extra", 1'b0, longint'(err_code_o), 0);
                    end else begin
                        e = exp_done.pop_front();
                        chk("frame_ok", frame_ok_o == e.ok, longint'(frame_ok_o), longint'(e.ok));
                        chk("err_code", err_code_o == e.err, longint'(err_code_o), longint'(e.err));
                    end
                end else if (frame_ok_o || err_code_o != 2'b00) begin
                    chk("status_idle", 1'b0, longint'({frame_ok_o, err_code_o}), 0);
                end
            end
        end
    end

    // Offer one byte until accepted; called at posedge+1.
    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        bit f;
        int n = 0;
        valid_i = 1'b1;
        data_i  = b;
        while (!acc) begin
            @(negedge clk_i);
            acc = ready_o;
            @(posedge clk_i);
            if (acc) begin
                f = model_byte(b);
                #1;
                if (f) chk("latency", valid_o && data_o == b,
                           longint'({valid_o, data_o}), longint'({1'b1, b}));
            end else begin
                #1;
                n++;
                if (n > 200) begin
                    chk("accept_timeout", 1'b0, n, 200);
                    break;
                end
            end
        end
        valid_i = 1'b0;
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk_i);
            #1;
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic send_crlf();
        send_byte(8'h0d);
        send_byte(8'h0a);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_fwd.size() != 0 || exp_done.size() != 0) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        chk("drain_timeout", n < 500, n, 500);
        @(negedge clk_i);
        chk("good_count", good_count_o == 16'(good_m), longint'(good_count_o), good_m);
        chk("bad_count", bad_count_o == 16'(bad_m), longint'(bad_count_o), bad_m);
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        @(posedge clk_i);
        in_frame = 1'b0;
        fr = {};
        exp_fwd = {};
        exp_done = {};
        good_m = 0;
        bad_m = 0;
        @(negedge clk_i);
        chk("rst_valid", valid_o == 1'b0, longint'(valid_o), 0);
        chk("rst_data", data_o == 8'h00, longint'(data_o), 0);
        chk("rst_status", {frame_done_o, frame_ok_o, err_code_o} == 4'b0,
            longint'({frame_done_o, frame_ok_o, err_code_o}), 0);
        chk("rst_counts", good_count_o == 16'd0 && bad_count_o == 16'd0,
            longint'({good_count_o, bad_count_o}), 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("ready_after_rst", ready_o == 1'b1, longint'(ready_o), 1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_random_sentence();
        logic [7:0] q[$];
        logic [7:0] x = 8'h00;
        logic [7:0] c;
        logic [7:0] hi;
        logic [7:0] lo;
        int blen;
        int kind;
        if ($urandom_range(0, 3) == 0)
            repeat ($urandom_range(1, 4)) q.push_back(8'($urandom_range(32, 126)));
        q.push_back("$");
        blen = ($urandom_range(0, 5) == 0) ? int'($urandom_range(70, 95))
                                           : int'($urandom_range(0, 30));
        for (int i = 0; i < blen; i++) begin
            c = 8'($urandom_range(32, 126));
            if (c == "*" || (c == "$" && $urandom_range(0, 9) != 0)) c = "A";
            q.push_back(c);
            x = x ^ c;
        end
        q.push_back("*");
        kind = $urandom_range(0, 9);
        hi = hexchar(x[7:4]);
        lo = hexchar(x[3:0]);
        if (kind == 0) lo = hexchar(4'(x[3:0] + 4'd1));
        if (kind == 1) hi = "g";
        if (kind == 2) lo = "z";
        q.push_back(hi);
        q.push_back(lo);
        q.push_back((kind == 3) ? 8'h20 : 8'h0d);
        q.push_back((kind == 4) ? 8'h58 : 8'h0a);
        foreach (q[i]) send_byte(q[i]);
    endtask

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        do_reset();

        // Directed sentences, downstream always ready.
        stall_pct = 0;
        send_str("$PMTK251,38400*27");
        send_crlf();
        drain();
        chk("dir_good1", good_count_o == 16'd1, longint'(good_count_o), 1);

        send_str("$PMTK251,38400*28");
        send_crlf();
        drain();
        chk("dir_bad1", bad_count_o == 16'd1, longint'(bad_count_o), 1);

        send_str("$PMTK251,38400*2g");
        send_crlf();
        send_str("$PMTK251,38400*27");
        send_crlf();
        drain();
        chk("dir_fmt", bad_count_o == 16'd2 && good_count_o == 16'd2,
            longint'({good_count_o, bad_count_o}), longint'({16'd2, 16'd2}));

        send_str("$GPVTG,1");
        send_str("$PMTK251,38400*27");
        send_crlf();
        drain();
        chk("dir_abort", bad_count_o == 16'd3 && good_count_o == 16'd3,
            longint'({good_count_o, bad_count_o}), longint'({16'd3, 16'd3}));

        send_byte("$");
        repeat (90) send_byte("A");
        send_str("$PMTK251,38400*27");
        send_crlf();
        drain();
        chk("dir_overlen", bad_count_o == 16'd4 && good_count_o == 16'd4,
            longint'({good_count_o, bad_count_o}), longint'({16'd4, 16'd4}));

        // Randomized traffic with stalls, gaps and mid-frame resets.
        stall_pct = 35;
        gaps_en   = 1'b1;
        for (int s = 0; s < 40; s++) begin
            send_random_sentence();
            if (s == 15 || s == 30) begin
                send_str("$GPGGA,12");
                do_reset();
            end
        end
        drain();

        stall_pct = 0;
        repeat (3) @(negedge clk_i);
        chk("fwd_left", exp_fwd.size() == 0, exp_fwd.size(), 0);
        chk("done_left", exp_done.size() == 0, exp_done.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
